// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg: shared state encoding and reference truth tables for gate sweeps
package gate_sweep_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
endpackage

// File: rtl/gate_sweep_if.sv
// gate_sweep_if: run-control, gate drive/observe and report signals of the sweep controller
interface gate_sweep_if;
  logic       start;
  logic       loop;
  logic       gate_x;
  logic       gate_y;
  logic       gate_z;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic [3:0] err_mask;
  logic       pass;
  logic [7:0] sweeps;
  logic [7:0] fails;
  modport master (
    output start, loop, gate_z,
    input  gate_x, gate_y, busy, done, result, err_mask, pass, sweeps, fails
  );
  modport slave (
    input  start, loop, gate_z,
    output gate_x, gate_y, busy, done, result, err_mask, pass, sweeps, fails
  );
endinterface

// File: rtl/gate_settle_timer.sv
// gate_settle_timer: loadable down-counter flagging the last settle cycle of a vector
module gate_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic expired
);
  localparam int W = $clog2(SETTLE + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= W'(SETTLE);
    else if (dec && cnt != '0) cnt <= cnt - W'(1);
  // flags the cycle whose ending edge brings the count to zero
  assign expired = cnt <= W'(1);
endmodule

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: sweeps a 2-input gate through all vectors and checks its truth table
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int         SETTLE   = 2,
  parameter logic [3:0] EXPECTED = TT_AND
) (
  input logic         clk,
  input logic         rst,
  gate_sweep_if.slave bus
);
  state_t     state;
  logic [1:0] idx;
  logic [1:0] nidx;
  logic [3:0] captured;
  logic       load;
  logic       expired;
  always_comb begin
    nidx     = idx + 2'd1;
    captured = bus.result | ({3'b000, bus.gate_z} << idx);
    load     = (state == IDLE && bus.start) || (state == SAMPLE && idx != 2'd3) ||
               (state == DONE && bus.loop);
  end
  gate_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .dec    (state == WAIT),
    .expired(expired)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      bus.gate_x   <= 1'b0;
      bus.gate_y   <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.result   <= '0;
      bus.err_mask <= '0;
      bus.pass     <= 1'b0;
      bus.sweeps   <= '0;
      bus.fails    <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state      <= WAIT;
          idx        <= '0;
          bus.gate_x <= 1'b0;
          bus.gate_y <= 1'b0;
          bus.result <= '0;
          bus.busy   <= 1'b1;
        end
        WAIT: if (expired) state <= SAMPLE;
        // idx wraps to 0 after the last vector, so 00 is already driven in DONE
        SAMPLE: begin
          bus.result <= captured;
          idx        <= nidx;
          bus.gate_x <= nidx[1];
          bus.gate_y <= nidx[0];
          state      <= idx == 2'd3 ? DONE : WAIT;
          if (idx == 2'd3) begin
            bus.done     <= 1'b1;
            bus.err_mask <= captured ^ EXPECTED;
            bus.pass     <= captured == EXPECTED;
            if (bus.sweeps != 8'hFF) bus.sweeps <= bus.sweeps + 8'd1;
            if (captured != EXPECTED && bus.fails != 8'hFF) bus.fails <= bus.fails + 8'd1;
          end
        end
        DONE: begin
          state    <= bus.loop ? WAIT : IDLE;
          bus.busy <= bus.loop;
          if (bus.loop) bus.result <= '0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
